// File: rtl/vertex_transform_unit_if.sv
// Handshake bundle between the vertex transform unit and its neighbours.
// The slave side is the transform unit itself: it takes a matrix and vertex
// on the input handshake and produces a transformed vertex on the output one.
interface vertex_transform_unit_if #(
  parameter int WIDTH = 16
) ();

  logic [15:0][WIDTH-1:0] matrix;      // row-major, [4*r+c]
  logic [3:0][WIDTH-1:0]  vertex_in;   // [0]=x .. [3]=w
  logic                   in_valid;
  logic                   in_ready;
  logic [3:0][WIDTH-1:0]  vertex_out;
  logic                   out_valid;
  logic                   out_ready;
  logic                   overflow;

  modport master (
    output matrix,
    output vertex_in,
    output in_valid,
    output out_ready,
    input  in_ready,
    input  vertex_out,
    input  out_valid,
    input  overflow
  );

  modport slave (
    input  matrix,
    input  vertex_in,
    input  in_valid,
    input  out_ready,
    output in_ready,
    output vertex_out,
    output out_valid,
    output overflow
  );

endinterface

// File: rtl/vertex_transform_unit.sv
// Vertex transform unit: multiplies a homogeneous Q8.8 vertex by a 4x4 Q8.8
// matrix using one time-shared signed MAC, one product per cycle, 16 cycles
// per vertex. Each row sum is rounded half-up and saturated to WIDTH bits.
module vertex_transform_unit #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 8,
  parameter int ACC_W = 36
) (
  input  logic                      clk,
  input  logic                      rst_n,
  vertex_transform_unit_if.slave    bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Rounding constant and saturation bounds, expressed in accumulator width
  localparam logic signed [ACC_W-1:0] HALF_LSB =
    {{(ACC_W-1){1'b0}}, 1'b1} << (FRAC-1);
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] OUT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] OUT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] ACC_ZERO = {ACC_W{1'b0}};

  state_e                   state_q, state_d;
  logic [15:0][WIDTH-1:0]   m_q, m_d;
  logic [3:0][WIDTH-1:0]    v_q, v_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [1:0]               row_q, row_d;
  logic [1:0]               col_q, col_d;
  logic [3:0][WIDTH-1:0]    vout_q, vout_d;
  logic                     ovf_q, ovf_d;
  logic                     in_ready_q, in_ready_d;
  logic                     out_valid_q, out_valid_d;

  logic signed [2*WIDTH-1:0] prod_s;
  logic signed [ACC_W-1:0]   sum_s;
  logic [WIDTH:0]            fin_s;   // {saturated, value}

  // Round half-up, drop FRAC bits, clamp to the signed WIDTH range.
  // Returns the saturation flag in the top bit.
  function automatic logic [WIDTH:0] round_sat(input logic signed [ACC_W-1:0] s);
    logic signed [ACC_W-1:0] rounded;
    logic signed [ACC_W-1:0] shifted;
    logic [WIDTH:0]          res;
    rounded = s + HALF_LSB;
    shifted = rounded >>> FRAC;
    if (shifted > SAT_MAX) begin
      res = {1'b1, OUT_MAX};
    end else if (shifted < SAT_MIN) begin
      res = {1'b1, OUT_MIN};
    end else begin
      res = {1'b0, shifted[WIDTH-1:0]};
    end
    return res;
  endfunction

  // MAC datapath: current product, running row sum and its finalised value
  always_comb begin
    prod_s = $signed(m_q[{row_q, col_q}]) * $signed(v_q[col_q]);
    sum_s  = acc_q + {{(ACC_W-2*WIDTH){prod_s[2*WIDTH-1]}}, prod_s};
    fin_s  = round_sat(sum_s);
  end

  // Next-state logic: accept in IDLE, 16 MAC steps, hold result in DONE
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    v_d     = v_q;
    acc_d   = acc_q;
    row_d   = row_q;
    col_d   = col_q;
    vout_d  = vout_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          state_d = ST_MAC;
          m_d     = bus.matrix;
          v_d     = bus.vertex_in;
          acc_d   = ACC_ZERO;
          row_d   = 2'd0;
          col_d   = 2'd0;
          ovf_d   = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MAC: begin
        col_d = col_q + 2'd1;
        if (col_q == 2'd3) begin
          // Last column of the row: commit the row and restart the sum
          acc_d         = ACC_ZERO;
          vout_d[row_q] = fin_s[WIDTH-1:0];
          ovf_d         = ovf_q | fin_s[WIDTH];
          row_d         = row_q + 2'd1;
          if (row_q == 2'd3) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_MAC;
          end
        end else begin
          acc_d = sum_s;
          row_d = row_q;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
  end

  // State and datapath registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      m_q         <= {(16*WIDTH){1'b0}};
      v_q         <= {(4*WIDTH){1'b0}};
      acc_q       <= ACC_ZERO;
      row_q       <= 2'd0;
      col_q       <= 2'd0;
      vout_q      <= {(4*WIDTH){1'b0}};
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      m_q         <= m_d;
      v_q         <= v_d;
      acc_q       <= acc_d;
      row_q       <= row_d;
      col_q       <= col_d;
      vout_q      <= vout_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.vertex_out = vout_q;
  assign bus.overflow   = ovf_q;

endmodule

// File: tb/tb_vertex_transform_unit.sv
// Randomised self-checking bench for vertex_transform_unit, compared against
// an integer-arithmetic matrix-vector reference model.
module tb_vertex_transform_unit;

  typedef logic [15:0][15:0] mat_t;
  typedef logic [3:0][15:0]  vec_t;

  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;

  vertex_transform_unit_if #(.WIDTH(16)) bus ();

  vertex_transform_unit #(.WIDTH(16), .FRAC(8), .ACC_W(36)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference: plain integer matrix-vector product, round half-up, clamp
  function automatic void ref_xform(input mat_t m, input vec_t v,
                                    output vec_t o, output logic ovf);
    longint s;
    ovf = 1'b0;
    for (int r = 0; r < 4; r++) begin
      s = 0;
      for (int c = 0; c < 4; c++) begin
        s += longint'($signed(m[4*r+c])) * longint'($signed(v[c]));
      end
      s = (s + 128) >>> 8;
      if (s > 32767) begin
        o[r] = 16'h7FFF; ovf = 1'b1;
      end else if (s < -32768) begin
        o[r] = 16'h8000; ovf = 1'b1;
      end else begin
        o[r] = 16'(s);
      end
    end
  endfunction

  function automatic logic [15:0] rand_elem();
    if ($urandom_range(0, 4) == 0) return 16'($urandom);
    return 16'($urandom_range(0, 2047)) - 16'd1024;
  endfunction

  task automatic scramble_inputs();
    for (int k = 0; k < 16; k++) bus.matrix[k] = 16'($urandom);
    for (int k = 0; k < 4; k++) bus.vertex_in[k] = 16'($urandom);
  endtask

  task automatic wait_out_valid(input string tag);
    int lat;
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'd16);
  endtask

  task automatic check_result(input string tag, input vec_t ev, input logic eo);
    for (int r = 0; r < 4; r++) begin
      check($sformatf("%s_out%0d", tag, r), 64'(bus.vertex_out[r]), 64'(ev[r]));
    end
    check({tag, "_ovf"}, 64'(bus.overflow), 64'(eo));
  endtask

  // One full transaction: accept, latency, result, optional stall, handshake
  task automatic do_transform(input string tag, input mat_t m, input vec_t v, input int stall);
    vec_t ev;
    logic eo;
    int   guard;
    ref_xform(m, v, ev, eo);
    guard = 0;
    while (!bus.in_ready && guard < 40) begin
      @(posedge clk); #1;
      guard++;
    end
    check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    bus.matrix = m;
    bus.vertex_in = v;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    scramble_inputs();
    check({tag, "_busy"}, 64'(bus.in_ready), 64'd0);
    wait_out_valid(tag);
    check_result(tag, ev, eo);
    repeat (stall) begin
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check({tag, "_ovalid_drop"}, 64'(bus.out_valid), 64'd0);
    check({tag, "_ready_back"}, 64'(bus.in_ready), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    mat_t m, ma, mb, id_m;
    vec_t v, va, vb, ev;
    logic eo;
    tests_run = 0;
    tests_failed = 0;
    clk = 1'b0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.matrix = '0;
    bus.vertex_in = '0;
    #12;
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_vertex_out", 64'(bus.vertex_out), 64'd0);
    check("rst_overflow", 64'(bus.overflow), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Identity
    id_m = '0;
    id_m[0] = 16'h0100; id_m[5] = 16'h0100; id_m[10] = 16'h0100; id_m[15] = 16'h0100;
    v = {16'h0100, 16'h0300, 16'h0200, 16'h0100};
    do_transform("identity", id_m, v, 0);
    check("identity_const", 64'(bus.vertex_out), 64'h0100_0300_0200_0100);

    // Projection-style
    m = '0;
    m[0] = 16'h0100; m[5] = 16'h0100; m[10] = 16'h0200; m[11] = 16'h0080; m[14] = 16'h0100;
    v = {4{16'h0100}};
    do_transform("proj", m, v, 1);
    check("proj_const", 64'(bus.vertex_out), 64'h0100_0280_0100_0100);

    // Saturation high, low, then a benign vertex clears overflow
    m = {16{16'h7FFF}};
    do_transform("sat_hi", m, {4{16'h7FFF}}, 0);
    check("sat_hi_const", 64'(bus.vertex_out), {4{16'h7FFF}});
    do_transform("sat_lo", m, {4{16'h8000}}, 0);
    check("sat_lo_const", 64'(bus.vertex_out), {4{16'h8000}});
    do_transform("sat_clear", id_m, {16'h0100, 16'h0300, 16'h0200, 16'h0100}, 0);

    // Rounding
    m = '0; m[0] = 16'h0080;
    v = '0; v[0] = 16'hFFFF;
    do_transform("round_neg", m, v, 0);
    check("round_neg_const", 64'(bus.vertex_out[0]), 64'h0000);
    m = '0; m[0] = 16'h0180;
    v = '0; v[0] = 16'h0001;
    do_transform("round_up", m, v, 0);
    check("round_up_const", 64'(bus.vertex_out[0]), 64'h0002);

    // Backpressure with a second vertex waiting
    for (int k = 0; k < 16; k++) begin ma[k] = rand_elem(); mb[k] = rand_elem(); end
    for (int k = 0; k < 4; k++) begin va[k] = rand_elem(); vb[k] = rand_elem(); end
    ref_xform(ma, va, ev, eo);
    bus.matrix = ma; bus.vertex_in = va; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    wait_out_valid("bp_a");
    bus.matrix = mb; bus.vertex_in = vb; bus.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_hold_out", 64'(bus.vertex_out), 64'(ev));
      check("bp_hold_ready", 64'(bus.in_ready), 64'd0);
      check("bp_hold_valid", 64'(bus.out_valid), 64'd1);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("bp_release_ready", 64'(bus.in_ready), 64'd1);
    check("bp_release_valid", 64'(bus.out_valid), 64'd0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("bp_b_accepted", 64'(bus.in_ready), 64'd0);
    ref_xform(mb, vb, ev, eo);
    wait_out_valid("bp_b");
    check_result("bp_b", ev, eo);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;

    // Reset during MAC
    bus.matrix = id_m; bus.vertex_in = {16'h0400, 16'h0300, 16'h0200, 16'h0100};
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mrst_out_valid", 64'(bus.out_valid), 64'd0);
    check("mrst_vertex_out", 64'(bus.vertex_out), 64'd0);
    check("mrst_in_ready", 64'(bus.in_ready), 64'd1);
    check("mrst_overflow", 64'(bus.overflow), 64'd0);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_transform("post_rst", id_m, {16'h0100, 16'h0300, 16'h0200, 16'h0100}, 0);

    // Randomised transforms with random output stalls
    for (int n = 0; n < 25; n++) begin
      for (int k = 0; k < 16; k++) m[k] = rand_elem();
      for (int k = 0; k < 4; k++) v[k] = rand_elem();
      do_transform($sformatf("rand%0d", n), m, v, int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
